// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the round-robin multiplexer slice.
//   MUX_MAX_CH  : largest supported channel count
//   MUX_PTR_W   : pointer field width able to index MUX_MAX_CH channels
//   ch_width()  : channel-index width, $clog2 with a floor of 1
//   arb_state_t : arbiter state (rotating pointer plus packet-lock flag)
// ---------------------------------------------------------------------------
package mux_pkg;

    localparam int MUX_MAX_CH = 16;
    localparam int MUX_PTR_W  = 4;

    // A single channel still needs a 1-bit index so ports never collapse.
    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // The pointer field is sized for the largest configuration; narrower
    // instances only use its low CH_W bits.
    typedef struct packed {
        logic                 lock;
        logic [MUX_PTR_W-1:0] ptr;
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority picker: grants the first requesting
// channel found searching upward from ptr, wrapping N_CH-1 -> 0.
// Ports:
//   req        in  N_CH  request vector
//   ptr        in  CH_W  channel with highest priority this cycle
//   gnt_onehot out N_CH  one-hot grant (zero when nothing requests)
//   gnt_idx    out CH_W  index of the granted channel (0 when none)
//   any        out 1     at least one request present
// ---------------------------------------------------------------------------
module rr_pick
    import mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] ptr,
    output logic [N_CH-1:0] gnt_onehot,
    output logic [CH_W-1:0] gnt_idx,
    output logic            any
);

    // Walk the channels in priority order starting at ptr; the first hit
    // wins and 'any' masks out every later candidate.
    always_comb begin
        int idx;
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        idx        = 0;
        for (int i = 0; i < N_CH; i++) begin
            idx = (int'(ptr) + i) % N_CH;
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_onehot[idx] = 1'b1;
                gnt_idx         = CH_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_rr_arb.sv
// ---------------------------------------------------------------------------
// mux_rr_arb
// N_CH-input, DATA_W-bit registered multiplexer with round-robin arbitration
// and valid/ready handshakes. A single output register accepts a new beat
// whenever it is empty or being consumed, giving full throughput.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid  [N_CH]    per-channel valid
//   in_data   [N_CH*W]  channel k at [k*DATA_W +: DATA_W]
//   in_ready  [N_CH]    one-hot (or zero) grant, combinational
//   out_valid/out_data  registered beat
//   out_ch    [CH_W]    source channel of the held beat
//   out_ready           consumer accepts the beat
// Optional feature, macro MUX_RR_ARB_LOCK_EN: adds in_last[N_CH] and
// registered out_last; a packet locks the grant to its channel until the
// beat marked last has transferred.
// ---------------------------------------------------------------------------
module mux_rr_arb
    import mux_pkg::*;
#(
    parameter  int N_CH   = 4,
    parameter  int DATA_W = 8,
    localparam int CH_W   = ch_width(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH-1:0]        in_valid,
    input  logic [N_CH*DATA_W-1:0] in_data,
    output logic [N_CH-1:0]        in_ready,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic [CH_W-1:0]        out_ch,
    input  logic                   out_ready
`ifdef MUX_RR_ARB_LOCK_EN
    ,
    input  logic [N_CH-1:0]        in_last,
    output logic                   out_last
`endif
);

    arb_state_t        st;
    arb_state_t        st_nxt;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   ptr_inc;
    logic [N_CH-1:0]   req;
    logic [N_CH-1:0]   gnt_onehot;
    logic [CH_W-1:0]   gnt_idx;
    logic              any;
    logic              load;
    logic [DATA_W-1:0] sel_data;
    logic              unused_st;

    assign ptr       = st.ptr[CH_W-1:0];
    assign unused_st = ^{st};
    assign load      = !out_valid || out_ready;

    // While locked, only the owning channel (held in ptr) may request.
`ifdef MUX_RR_ARB_LOCK_EN
    assign req = st.lock ? (in_valid & (N_CH'(1) << ptr)) : in_valid;
`else
    assign req = in_valid;
`endif

    rr_pick #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_pick (
        .req        (req),
        .ptr        (ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    // Gating with rst_n keeps in_ready low while the block is held in reset.
    assign in_ready = (load && rst_n) ? gnt_onehot : '0;

    // One-hot AND-OR data select so the grant path never sees in_data.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (gnt_onehot[k]) begin
                sel_data = in_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next arbiter state after a transfer: advance past the winner, or,
    // in a non-final packet beat, park the pointer on it and lock.
    always_comb begin
        st_nxt  = st;
        ptr_inc = (gnt_idx == CH_W'(N_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
        st_nxt.ptr  = MUX_PTR_W'(ptr_inc);
        st_nxt.lock = 1'b0;
`ifdef MUX_RR_ARB_LOCK_EN
        if (!(|(in_last & gnt_onehot))) begin
            st_nxt.ptr  = MUX_PTR_W'(gnt_idx);
            st_nxt.lock = 1'b1;
        end
`endif
    end

    // Output register and arbiter state: load on a transfer, empty when the
    // slot frees up with nobody requesting, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            st        <= '0;
        end else if (load) begin
            if (any) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_ch    <= gnt_idx;
                st        <= st_nxt;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef MUX_RR_ARB_LOCK_EN
    // The last flag travels with its beat through the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_last <= 1'b0;
        end else if (load && any) begin
            out_last <= |(in_last & gnt_onehot);
        end
    end
`endif

endmodule

// File: tb/tb_mux_rr_arb.sv
// ---------------------------------------------------------------------------
// tb_mux_rr_arb
// Randomized scoreboard bench for mux_rr_arb (N_CH=4, DATA_W=8). Producers
// hold each offered beat until it transfers; a reference arbiter predicts
// grants and queues expected beats, and a monitor pops them whenever the
// DUT hands a beat to the consumer. Works with or without
// MUX_RR_ARB_LOCK_EN defined.
// ---------------------------------------------------------------------------
module tb_mux_rr_arb;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = 2;
`ifdef MUX_RR_ARB_LOCK_EN
    localparam bit LOCK_MODE = 1'b1;
`else
    localparam bit LOCK_MODE = 1'b0;
`endif

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [CW-1:0]  out_ch;
    logic           out_ready;
    logic [N-1:0]   in_last;
    logic           out_last_obs;
`ifdef MUX_RR_ARB_LOCK_EN
    logic           out_last;
    assign out_last_obs = out_last;
`else
    assign out_last_obs = 1'b1;
`endif

    mux_rr_arb #(
        .N_CH   (N),
        .DATA_W (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
`ifdef MUX_RR_ARB_LOCK_EN
        ,
        .in_last   (in_last),
        .out_last  (out_last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Producer-side state: an offered beat stays pending until it transfers.
    bit       pend  [N];
    bit [W-1:0] pdata [N];
    bit       plast [N];

    // Reference arbiter state.
    int m_ptr;
    bit m_ov;
    bit m_lock;
    int m_lch;

    // Scoreboard of beats the DUT still owes the consumer.
    logic [W-1:0]  exp_data [$];
    logic [CW-1:0] exp_ch   [$];
    logic          exp_last [$];

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic modelReset();
        m_ptr  = 0;
        m_ov   = 1'b0;
        m_lock = 1'b0;
        m_lch  = 0;
        exp_data.delete();
        exp_ch.delete();
        exp_last.delete();
    endtask

    // Called 1 time unit after a rising edge: drives one cycle of inputs,
    // then predicts that cycle's handshake from the arbitration rules.
    task automatic applyStimulus(input int vprob, input int rprob,
                                 input logic [N-1:0] mask, input bit fixed);
        bit          ld;
        int          g;
        logic [N-1:0] exp_rdy;
        for (int k = 0; k < N; k++) begin
            if (!pend[k] && mask[k] && ($urandom % 100) < vprob) begin
                pend[k]  = 1'b1;
                pdata[k] = fixed ? W'(8'hA0 + k) : W'($urandom);
                plast[k] = fixed ? 1'b1 : 1'($urandom % 2);
            end
            in_valid[k]         = pend[k];
            in_data[k*W +: W]   = pdata[k];
            in_last[k]          = plast[k];
        end
        out_ready = (($urandom % 100) < rprob);
        #1;
        ld = !m_ov || out_ready;
        g  = -1;
        if (ld) begin
            if (m_lock) begin
                if (pend[m_lch]) g = m_lch;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (g < 0 && pend[(m_ptr + i) % N]) g = (m_ptr + i) % N;
                end
            end
        end
        exp_rdy = (g >= 0) ? N'(1 << g) : '0;
        checkOutput("in_ready", 32'(in_ready), 32'(exp_rdy));
        checkOutput("out_valid", 32'(out_valid), 32'(m_ov));
        if (g >= 0) begin
            exp_data.push_back(pdata[g]);
            exp_ch.push_back(CW'(g));
            exp_last.push_back(LOCK_MODE ? plast[g] : 1'b1);
            pend[g] = 1'b0;
            m_ov    = 1'b1;
            if (LOCK_MODE && !plast[g]) begin
                m_lock = 1'b1;
                m_lch  = g;
            end else begin
                m_lock = 1'b0;
                m_ptr  = (g + 1) % N;
            end
        end else if (ld) begin
            m_ov = 1'b0;
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every beat accepted by the consumer must match the oldest
    // predicted beat.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_data.size() == 0) begin
                checkOutput("unexpected_beat", 32'(out_valid), 32'h0);
            end else begin
                checkOutput("out_data", 32'(out_data), 32'(exp_data.pop_front()));
                checkOutput("out_ch", 32'(out_ch), 32'(exp_ch.pop_front()));
                checkOutput("out_last", 32'(out_last_obs), 32'(exp_last.pop_front()));
            end
        end
    end

    initial begin
        int sent1;
        rst_n     = 1'b0;
        in_valid  = '1;
        in_data   = '0;
        in_last   = '0;
        out_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            pend[k]  = 1'b0;
            pdata[k] = '0;
            plast[k] = 1'b0;
        end
        modelReset();

        // Reset values, with requests present to show in_ready stays low.
        nextCycle();
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_out_data", 32'(out_data), 32'h0);
        checkOutput("rst_out_ch", 32'(out_ch), 32'h0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'h0);
        in_valid = '0;
        nextCycle();
        rst_n = 1'b1;

        // Idle after reset.
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 100, '1, 1'b0);
            checkOutput("idle_out_ch", 32'(out_ch), 32'h0);
            nextCycle();
        end

        // All channels streaming A0+k at full rate.
        for (int c = 0; c < 8; c++) begin
            applyStimulus(100, 100, '1, 1'b1);
            nextCycle();
        end

        // Drain, then steer the pointer to 2 via a lone beat on channel 1,
        // then offer only channels 0 and 3.
        for (int c = 0; c < 12; c++) begin
            applyStimulus(0, 100, '0, 1'b0);
            nextCycle();
        end
        applyStimulus(100, 100, 4'b0010, 1'b1);
        nextCycle();
        for (int c = 0; c < 6; c++) begin
            applyStimulus(100, 100, 4'b1001, 1'b1);
            nextCycle();
        end

        // Backpressure for four cycles, then release.
        for (int c = 0; c < 4; c++) begin
            applyStimulus(100, 0, '1, 1'b1);
            nextCycle();
        end
        for (int c = 0; c < 4; c++) begin
            applyStimulus(100, 100, '1, 1'b1);
            nextCycle();
        end

        // Reset while a beat is held: it is dropped, arbitration restarts at 0.
        applyStimulus(100, 0, '1, 1'b1);
        nextCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'h0);
        modelReset();
        for (int k = 0; k < N; k++) begin
            pend[k]  = 1'b1;
            pdata[k] = W'(8'hA0 + k);
            plast[k] = 1'b1;
        end
        nextCycle();
        rst_n = 1'b1;
        applyStimulus(100, 100, '1, 1'b1);
        checkOutput("post_rst_grant", 32'(in_ready), 32'h1);
        nextCycle();

        // Packet on channel 1 (last on third beat) competing with channel 2.
        if (LOCK_MODE) begin
            for (int c = 0; c < 12; c++) begin
                applyStimulus(0, 100, '0, 1'b0);
                nextCycle();
            end
            sent1    = 0;
            pend[2]  = 1'b1;
            pdata[2] = 8'h22;
            plast[2] = 1'b1;
            for (int c = 0; c < 8; c++) begin
                if (!pend[1] && sent1 < 3) begin
                    pend[1]  = 1'b1;
                    pdata[1] = W'(8'h10 + sent1);
                    plast[1] = (sent1 == 2);
                    sent1++;
                end
                applyStimulus(0, 100, '0, 1'b0);
                nextCycle();
            end
        end

        // Random traffic and backpressure.
        for (int c = 0; c < 400; c++) begin
            applyStimulus(40, 70, '1, 1'b0);
            nextCycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mux_rr_arb.md
# mux_rr_arb

Parametrised N-channel, W-bit registered multiplexer with round-robin arbitration and valid/ready handshakes on every channel. It replaces the fixed-width, select-driven mux family. Selection comes from a fair internal arbiter instead of an external `sel`. The output is registered, with backpressure. It sits between multiple producer streams and a single shared consumer port.

## Interface
- `N_CH`, default 4: number of input channels, 1..16.
- `DATA_W`, default 8: data width per channel, at least 1.
- `CH_W`, default `$clog2(N_CH)` (minimum 1): width of the channel-index output; derived, not overridden.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  N_CH  per-channel valid.
- `in_data`  in  N_CH*DATA_W  channel k occupies bits `[k*DATA_W +: DATA_W]`.
- `in_ready`  out  N_CH  per-channel ready; one-hot or zero.
- `out_valid`  out  1  output register holds a beat.
- `out_data`  out  DATA_W  registered data.
- `out_ch`  out  CH_W  source channel of the held beat.
- `out_ready`  in  1  consumer accepts the beat.

## Operation
- Output stage is a single-entry register. Load enable: `load = !out_valid || out_ready`.
- Grant selection: the first channel with `in_valid=1`, searching upward from `ptr` and wrapping from N_CH-1 to 0.
- `in_ready[g]=1` only when `load=1` and g is the granted channel. All other `in_ready` bits are 0.
- `in_ready` is combinational from `in_valid`, `ptr` and `out_ready`. `in_ready` must not depend on `in_data`.
- A transfer on channel g occurs when `in_valid[g] && in_ready[g]`. On that edge:
  - `out_data` takes `in_data[g]`.
  - `out_ch` takes g.
  - `out_valid` is set to 1.
  - `ptr` takes (g+1) mod N_CH.
- Idle cases:
  - If `load=1` and no channel is valid, `out_valid` becomes 0.
  - `out_data`, `out_ch` and `ptr` hold their values.
- Backpressure:
  - While `out_valid=1` and `out_ready=0`, all outputs hold.
  - All `in_ready` bits are 0 during this time.
- Simultaneous consume and load: a new beat replaces the consumed beat in the same cycle. There is no bubble, so full throughput is 1 beat per cycle.
- Fairness: with all N_CH channels continuously valid, each channel is granted exactly once every N_CH consecutive transfers.
- N_CH=1: `ptr` stays 0 and the block reduces to a registered pipeline stage.

## Timing
- Latency: 1 cycle from input transfer to `out_valid`/`out_data`.
- Reset values, applied asynchronously on `rst_n` low:
  - `out_valid=0`, `out_data=0`, `out_ch=0`, `ptr=0`.
  - `in_ready` is 0 only while `rst_n` is low; it is combinational and recomputes after reset release.
- Reset asserted mid-operation: the held beat is dropped. Arbitration restarts at channel 0.
- First grant is possible in the first clock edge after `rst_n` deasserts.
- Producers must hold `in_valid`/`in_data` stable until transfer. This is not checked in RTL.

## Configuration
- `MUX_RR_ARB_LOCK_EN` defined: adds packet lock.
  - New ports: `in_last` in, N_CH wide; `out_last` out, 1 wide, registered, reset 0.
  - After a transfer on channel g with `in_last[g]=0`, the grant is locked to g. It stays locked until a transfer on g with `in_last[g]=1`; then `ptr` takes g+1 and the lock clears.
  - While locked, other channels are never granted, even if g drops `in_valid`.
  - The lock flag resets to 0.
- Not defined:
  - `in_last` and `out_last` ports are absent.
  - Arbitration is per beat, exactly as described in Operation.

## Structure
- Shared package `mux_pkg`:
  - `MUX_MAX_CH = 16`.
  - Function `ch_width(n)`, returning `$clog2` with a minimum of 1.
  - Typedef for the arbiter state: pointer plus lock flag.
- Sub-module `rr_pick`: combinational rotating priority picker.
  - Inputs: `req[N_CH]`, `ptr[CH_W]`.
  - Outputs: `gnt_onehot[N_CH]`, `gnt_idx[CH_W]`, `any`.
  - The top level adds the output register, pointer update and lock logic.

## Test plan
- Reset, then all channels idle: `out_valid=0`, `out_ch=0`, and `in_ready=0000` for 3 cycles.
- N_CH=4, all `in_valid=1`, data = 8'hA0+k on channel k, `out_ready=1`:
  - outputs read A0, A1, A2, A3, A0 on consecutive cycles;
  - `out_ch` reads 0, 1, 2, 3, 0.
- `ptr=2`, only channels 0 and 3 valid: grant goes to 3, then 0, then 3.
- `out_ready=0` for 4 cycles with `out_valid=1`: `out_data` is stable, `in_ready=0000`. On release, the next beat loads in the same cycle the held beat is consumed.
- `rst_n` pulsed low while `out_valid=1` and `out_ch=2`: `out_valid` drops immediately. The first post-reset grant with all channels valid goes to channel 0.
- With `MUX_RR_ARB_LOCK_EN` defined, channel 1 sends 3 beats with last on beat 3, while channel 2 is valid throughout:
  - `out_ch` reads 1, 1, 1, then 2;
  - `out_last` is 1 only on the third beat.
